// File: rtl/mem_arbiter.sv
// Two-requester (instruction fetch / data memory) arbiter onto a single-port memory
// with fixed MEM_LAT read latency. Define ARB_RR_EN to break ties by alternating grants.
module mem_arbiter #(
   parameter int MEM_LAT = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        if_req_i,
   input  logic [31:0] if_addr_i,
   output logic        if_ack_o,
   output logic [31:0] if_data_o,
   input  logic        dm_req_i,
   input  logic        dm_we_i,
   input  logic [31:0] dm_addr_i,
   input  logic [31:0] dm_wdata_i,
   output logic        dm_ack_o,
   output logic [31:0] dm_rdata_o,
   output logic        mem_en_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic [31:0] mem_rdata_i,
   output logic        busy_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   localparam logic [3:0] LAT_LAST = 4'(MEM_LAT - 1);

   state_t      state_reg, state_next;
   logic [3:0]  cnt_reg, cnt_next;
   logic        any_req;
   logic        grant_dm;

   logic        gnt_dm_reg, gnt_dm_next;
   logic        lat_we_reg, lat_we_next;
   logic        if_ack_reg, if_ack_next;
   logic [31:0] if_data_reg, if_data_next;
   logic        dm_ack_reg, dm_ack_next;
   logic [31:0] dm_rdata_reg, dm_rdata_next;
   logic        mem_en_reg, mem_en_next;
   logic        mem_we_reg, mem_we_next;
   logic [31:0] mem_addr_reg, mem_addr_next;
   logic [31:0] mem_wdata_reg, mem_wdata_next;
   logic        busy_reg, busy_next;

   assign any_req = if_req_i | dm_req_i;

`ifdef ARB_RR_EN
   // Remembers who won the last grant; reset to IF so the first tie goes to DM.
   logic last_dm_reg;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         last_dm_reg <= 1'b0;
      end else if (state_reg == IDLE && any_req) begin
         last_dm_reg <= grant_dm;
      end
   end

   assign grant_dm = dm_req_i & (~if_req_i | ~last_dm_reg);
`else
   assign grant_dm = dm_req_i;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg <= IDLE;
         cnt_reg   <= 4'd0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         IDLE:  if (any_req) state_next = ISSUE;
         ISSUE: begin
            state_next = WAIT;
            cnt_next   = 4'd0;
         end
         WAIT: begin
            if (cnt_reg == LAT_LAST) state_next = RESP;
            else                     cnt_next   = cnt_reg + 4'd1;
         end
         RESP:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Outputs are computed one cycle early so every port comes straight from a flop.
   always_comb begin
      gnt_dm_next    = gnt_dm_reg;
      lat_we_next    = lat_we_reg;
      if_ack_next    = 1'b0;
      if_data_next   = if_data_reg;
      dm_ack_next    = 1'b0;
      dm_rdata_next  = dm_rdata_reg;
      mem_en_next    = 1'b0;
      mem_we_next    = 1'b0;
      mem_addr_next  = mem_addr_reg;
      mem_wdata_next = mem_wdata_reg;
      busy_next      = (state_next != IDLE);
      case (state_reg)
         IDLE: begin
            if (any_req) begin
               gnt_dm_next    = grant_dm;
               lat_we_next    = grant_dm & dm_we_i;
               mem_en_next    = 1'b1;
               mem_we_next    = grant_dm & dm_we_i;
               mem_addr_next  = grant_dm ? dm_addr_i : if_addr_i;
               mem_wdata_next = grant_dm ? dm_wdata_i : 32'd0;
            end
         end
         WAIT: begin
            if (cnt_reg == LAT_LAST) begin
               if (gnt_dm_reg) begin
                  dm_ack_next = 1'b1;
                  if (!lat_we_reg) dm_rdata_next = mem_rdata_i;
               end else begin
                  if_ack_next  = 1'b1;
                  if_data_next = mem_rdata_i;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         gnt_dm_reg    <= 1'b0;
         lat_we_reg    <= 1'b0;
         if_ack_reg    <= 1'b0;
         if_data_reg   <= 32'd0;
         dm_ack_reg    <= 1'b0;
         dm_rdata_reg  <= 32'd0;
         mem_en_reg    <= 1'b0;
         mem_we_reg    <= 1'b0;
         mem_addr_reg  <= 32'd0;
         mem_wdata_reg <= 32'd0;
         busy_reg      <= 1'b0;
      end else begin
         gnt_dm_reg    <= gnt_dm_next;
         lat_we_reg    <= lat_we_next;
         if_ack_reg    <= if_ack_next;
         if_data_reg   <= if_data_next;
         dm_ack_reg    <= dm_ack_next;
         dm_rdata_reg  <= dm_rdata_next;
         mem_en_reg    <= mem_en_next;
         mem_we_reg    <= mem_we_next;
         mem_addr_reg  <= mem_addr_next;
         mem_wdata_reg <= mem_wdata_next;
         busy_reg      <= busy_next;
      end
   end

   assign if_ack_o    = if_ack_reg;
   assign if_data_o   = if_data_reg;
   assign dm_ack_o    = dm_ack_reg;
   assign dm_rdata_o  = dm_rdata_reg;
   assign mem_en_o    = mem_en_reg;
   assign mem_we_o    = mem_we_reg;
   assign mem_addr_o  = mem_addr_reg;
   assign mem_wdata_o = mem_wdata_reg;
   assign busy_o      = busy_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Random-traffic bench for mem_arbiter: a cycle-numbered reference model predicts grants
// and ack cycles into a scoreboard queue that a separate monitor drains and compares.
module tb_mem_arbiter;

   localparam int MEM_LAT    = 2;
   localparam int RUN_CYCLES = 4000;
   localparam int DRAIN      = 60;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        if_req_i;
   logic [31:0] if_addr_i;
   logic        if_ack_o;
   logic [31:0] if_data_o;
   logic        dm_req_i;
   logic        dm_we_i;
   logic [31:0] dm_addr_i;
   logic [31:0] dm_wdata_i;
   logic        dm_ack_o;
   logic [31:0] dm_rdata_o;
   logic        mem_en_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic [31:0] mem_rdata_i;
   logic        busy_o;

   always #5 clk = ~clk;

   mem_arbiter #(.MEM_LAT(MEM_LAT)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_ack_o(if_ack_o), .if_data_o(if_data_o),
      .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
      .dm_ack_o(dm_ack_o), .dm_rdata_o(dm_rdata_o),
      .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .busy_o(busy_o)
   );

   typedef struct {
      bit          is_dm;
      int          ack_cyc;
      bit          is_read;
      logic [31:0] rdata;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   n_acks = 0;

   // Reference model state: one transaction in flight, described by cycle numbers.
   int          cyc = 0;
   bit          done = 1'b0;
   bit          in_flight = 1'b0;
   bit          fl_dm, fl_we;
   int          t_issue, t_ack;
   int          free_at = 0;
   logic [31:0] fl_addr, fl_wdata;
`ifdef ARB_RR_EN
   bit          rr_last_dm = 1'b0;
`endif

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, req);
      end
   endtask

   // Model + driver: model steps at each rising edge, stimulus changes on falling edges.
   initial begin
      bit out_if = 1'b0;
      bit out_dm = 1'b0;
      bit g_dm;
      int rst_cnt = 3;
      rst_i = 1'b1;
      if_req_i = 1'b0; if_addr_i = '0;
      dm_req_i = 1'b0; dm_we_i = 1'b0; dm_addr_i = '0; dm_wdata_i = '0;
      mem_rdata_i = '0;
      for (int k = 0; k < RUN_CYCLES + DRAIN; k++) begin
         @(posedge clk);
         if (rst_i) begin
            in_flight = 1'b0;
            free_at   = cyc + 1;
`ifdef ARB_RR_EN
            rr_last_dm = 1'b0;
`endif
         end else begin
            if (in_flight && cyc == t_ack) in_flight = 1'b0;
            if (cyc >= free_at && (if_req_i || dm_req_i)) begin
`ifdef ARB_RR_EN
               g_dm = dm_req_i && (!if_req_i || !rr_last_dm);
               rr_last_dm = g_dm;
`else
               g_dm = dm_req_i;
`endif
               in_flight = 1'b1;
               fl_dm    = g_dm;
               fl_we    = g_dm ? dm_we_i : 1'b0;
               fl_addr  = g_dm ? dm_addr_i : if_addr_i;
               fl_wdata = dm_wdata_i;
               t_issue  = cyc + 1;
               t_ack    = cyc + MEM_LAT + 2;
               free_at  = cyc + MEM_LAT + 3;
               exp_q.push_back('{g_dm, t_ack, !fl_we, mem_word(fl_addr)});
            end
         end
         cyc++;

         @(negedge clk);
         if (in_flight && cyc == t_issue + MEM_LAT) mem_rdata_i = mem_word(fl_addr);
         else                                       mem_rdata_i = $urandom();

         if (rst_i) begin
            if (rst_cnt > 0) rst_cnt--;
            else             rst_i = 1'b0;
         end else if (k < RUN_CYCLES && $urandom_range(0, 299) == 0) begin
            rst_i   = 1'b1;
            rst_cnt = $urandom_range(0, 1);
         end

         if (out_if) begin
            if (if_ack_o) begin
               out_if = 1'b0;
               if_req_i = 1'b0;
            end else if (!if_req_i && !(in_flight && !fl_dm)) begin
               out_if = 1'b0;
            end else if (in_flight && !fl_dm && if_req_i) begin
               if ($urandom_range(0, 7) == 0)      if_req_i = 1'b0;
               else if ($urandom_range(0, 3) == 0) if_addr_i = $urandom();
            end
         end
         if (!out_if && k < RUN_CYCLES && $urandom_range(0, 3) == 0) begin
            out_if    = 1'b1;
            if_req_i  = 1'b1;
            if_addr_i = $urandom() & 32'hFFFF_FFFC;
         end

         if (out_dm) begin
            if (dm_ack_o) begin
               out_dm = 1'b0;
               dm_req_i = 1'b0;
            end else if (!dm_req_i && !(in_flight && fl_dm)) begin
               out_dm = 1'b0;
            end else if (in_flight && fl_dm && dm_req_i) begin
               if ($urandom_range(0, 7) == 0) dm_req_i = 1'b0;
               else if ($urandom_range(0, 3) == 0) begin
                  dm_we_i    = $urandom_range(0, 1) == 1;
                  dm_addr_i  = $urandom();
                  dm_wdata_i = $urandom();
               end
            end
         end
         if (!out_dm && k < RUN_CYCLES && $urandom_range(0, 2) == 0) begin
            out_dm     = 1'b1;
            dm_req_i   = 1'b1;
            dm_we_i    = $urandom_range(0, 1) == 1;
            dm_addr_i  = $urandom() & 32'hFFFF_FFFC;
            dm_wdata_i = $urandom();
         end
      end
      done = 1'b1;
   end

   // Monitor: checks every cycle #1 after the rising edge and drains the scoreboard.
   initial begin
      bit          r;
      bit          exp_busy, exp_en;
      exp_t        e;
      logic [31:0] exp_if_data = '0;
      logic [31:0] exp_dm_data = '0;
      forever begin
         @(posedge clk);
         r = rst_i;
         #1;
         if (done) break;
         if (r) begin
            exp_q.delete();
            exp_if_data = '0;
            exp_dm_data = '0;
            chk("rst_ctrl", {59'd0, if_ack_o, dm_ack_o, mem_en_o, mem_we_o, busy_o}, 64'd0);
            chk("rst_data", {if_data_o, dm_rdata_o}, 64'd0);
            chk("rst_mem", {mem_addr_o, mem_wdata_o}, 64'd0);
            continue;
         end

         exp_busy = in_flight && cyc >= t_issue && cyc <= t_ack;
         exp_en   = in_flight && cyc == t_issue;
         chk("busy", busy_o, exp_busy);
         chk("mem_en", mem_en_o, exp_en);
         chk("mem_we", mem_we_o, exp_en && fl_we);
         if (exp_busy && cyc < t_ack) begin
            chk("mem_addr", mem_addr_o, fl_addr);
            if (fl_we) chk("mem_wdata", mem_wdata_o, fl_wdata);
         end

         chk("ack_overlap", if_ack_o & dm_ack_o, 1'b0);
         if (if_ack_o || dm_ack_o) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_ack", {62'd0, if_ack_o, dm_ack_o}, 64'd0);
            end else begin
               e = exp_q.pop_front();
               n_acks++;
               chk("ack_port", dm_ack_o, e.is_dm);
               chk("ack_cycle", cyc, e.ack_cyc);
               if (e.is_read) begin
                  if (e.is_dm) exp_dm_data = e.rdata;
                  else         exp_if_data = e.rdata;
               end
            end
         end else if (exp_q.size() > 0 && exp_q[0].ack_cyc < cyc) begin
            chk("missing_ack", cyc, exp_q[0].ack_cyc);
            void'(exp_q.pop_front());
         end
         chk("if_data", if_data_o, exp_if_data);
         chk("dm_rdata", dm_rdata_o, exp_dm_data);
      end
      chk("scoreboard_empty", exp_q.size(), 0);
      chk("acks_seen", n_acks > 100, 1'b1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter: MEM_LAT, 2, cycles from memory issue cycle to valid mem_rdata_i (legal 1..15).
REQ-002 The block SHALL have port: clk_i  input  1  single clock; all logic on rising edge.
REQ-003 The block SHALL have port: rst_i  input  1  reset, synchronous, active-high.
REQ-004 The block SHALL have port: if_req_i  input  1  instruction-fetch request, held until if_ack_o.
REQ-005 The block SHALL have port: if_addr_i  input  32  fetch address.
REQ-006 The block SHALL have port: if_ack_o  output  1  one-cycle fetch completion pulse.
REQ-007 The block SHALL have port: if_data_o  output  32  fetched instruction, valid while if_ack_o=1.
REQ-008 The block SHALL have port: dm_req_i  input  1  data-memory request, held until dm_ack_o.
REQ-009 The block SHALL have port: dm_we_i  input  1  1=write, 0=read.
REQ-010 The block SHALL have port: dm_addr_i  input  32  data address.
REQ-011 The block SHALL have port: dm_wdata_i  input  32  write data.
REQ-012 The block SHALL have port: dm_ack_o  output  1  one-cycle data completion pulse.
REQ-013 The block SHALL have port: dm_rdata_o  output  32  read data, valid while dm_ack_o=1 after a read.
REQ-014 The block SHALL have port: mem_en_o  output  1  single-port memory access strobe.
REQ-015 The block SHALL have port: mem_we_o  output  1  memory write strobe.
REQ-016 The block SHALL have port: mem_addr_o  output  32  memory address.
REQ-017 The block SHALL have port: mem_wdata_o  output  32  memory write data.
REQ-018 The block SHALL have port: mem_rdata_i  input  32  memory read data.
REQ-019 The block SHALL have port: busy_o  output  1  high whenever state is not IDLE.

Function
REQ-020 The FSM SHALL have states IDLE, ISSUE, WAIT, RESP; all outputs registered.
REQ-021 IDLE: if any request is high, the FSM SHALL grant one requester, latch its address, we and wdata (IF: we=0), and go to ISSUE; otherwise stay IDLE.
REQ-022 ISSUE (1 cycle): mem_en_o=1, mem_we_o=latched we, mem_addr_o/mem_wdata_o=latched values; next state WAIT with wait counter=0.
REQ-023 WAIT SHALL last exactly MEM_LAT cycles; mem_addr_o/mem_wdata_o stay stable, mem_en_o=mem_we_o=0; on the last WAIT cycle mem_rdata_i SHALL be captured for reads.
REQ-024 RESP (1 cycle): granted requester's ack SHALL be 1, and its data output SHALL present the captured word (reads only; on writes the data output holds its previous value); next state IDLE unconditionally.
REQ-025 Latency: request high in IDLE cycle T -> ack in cycle T+MEM_LAT+2; back-to-back service period MEM_LAT+3 cycles.
REQ-026 Default arbitration: when both requests are high in IDLE, DM SHALL win; IF may starve while DM requests continuously.
REQ-027 Inputs changing after grant SHALL be ignored; a request dropped mid-transaction SHALL still complete and pulse ack.
REQ-028 Ack SHALL never be asserted for the non-granted requester; both acks SHALL never be high together.

Reset
REQ-029 While rst_i=1 at a rising edge the FSM SHALL enter IDLE and all outputs SHALL become 0 (acks, data outputs, mem_* outputs, busy_o), wait counter 0, last-grant register=IF.
REQ-030 Reset mid-transaction SHALL abort it with no ack; requests still high after release SHALL be re-arbitrated from IDLE.

Configuration
REQ-031 Macro ARB_RR_EN defined: ties in IDLE SHALL go to the requester not granted last (last-grant register updated at every grant, reset value IF, so first tie goes to DM).
REQ-032 Macro ARB_RR_EN undefined: fixed DM priority per REQ-026; last-grant register absent.

Verification
REQ-033 IF read 0x00000010, mem_rdata_i=0x20010005 in cycle T+3 -> if_ack_o=1 and if_data_o=0x20010005 in cycle T+4 only; mem_en_o=1, mem_addr_o=0x10 in cycle T+1 only.
REQ-034 DM write addr 0x00000040 data 0xDEADBEEF -> cycle T+1 mem_en_o=mem_we_o=1, addr 0x40, wdata 0xDEADBEEF; dm_ack_o at T+4; dm_rdata_o unchanged.
REQ-035 Both requests at T, macro off -> DM acked T+4, IF acked T+9; IF never served while dm_req_i held high.
REQ-036 Macro on, both requests held for 4 transactions -> grant order DM, IF, DM, IF; acks at T+4, T+9, T+14, T+19.
REQ-037 rst_i=1 in cycle T+2 of a DM read -> from T+3 all outputs 0, no dm_ack_o; after release with dm_req_i high, new ISSUE follows one IDLE cycle later.
REQ-038 if_req_i dropped in cycle T+2 -> if_ack_o still pulses at T+4, then IDLE with busy_o=0.
